// File: rtl/uart_num_tokenizer_pkg.sv
// Shared constants for the UART number tokenizer.
// Holds the FSM state encoding, the error codes reported on o_err_code,
// and the ASCII values the character classifier recognises.
// Optional feature macro: UART_NUM_TOKENIZER_NEG_EN (signed tokens).
package uart_num_tokenizer_pkg;

   // FSM state encoding (NEG is only reachable with signed tokens enabled)
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DIGITS = 2'd1;
   localparam logic [1:0] ST_NEG    = 2'd2;
   localparam logic [1:0] ST_SKIP   = 2'd3;

   // Rejection reasons
   localparam logic [1:0] ERR_BADCHAR = 2'd1;
   localparam logic [1:0] ERR_OVF     = 2'd2;
   localparam logic [1:0] ERR_SIGN    = 2'd3;

   // ASCII constants
   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_MINUS = 8'h2D;
   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_NINE  = 8'h39;

endpackage

// File: rtl/uart_num_tokenizer_ascii_char_classify.sv
// Purely combinational ASCII character classifier.
// Ports:
//   rx_byte   in  8  byte to classify
//   is_digit  out 1  byte is '0'..'9'
//   is_delim  out 1  byte is space, CR or LF
//   is_minus  out 1  byte is '-'
//   digit_val out 4  numeric value of the byte when is_digit is set
module ascii_char_classify
   import uart_num_tokenizer_pkg::*;
(
   input  logic [7:0] rx_byte,
   output logic       is_digit,
   output logic       is_delim,
   output logic       is_minus,
   output logic [3:0] digit_val
);

   assign is_digit = (rx_byte >= ASCII_ZERO) && (rx_byte <= ASCII_NINE);
   assign is_delim = (rx_byte == ASCII_SPACE) || (rx_byte == ASCII_CR) ||
                     (rx_byte == ASCII_LF);
   assign is_minus = (rx_byte == ASCII_MINUS);

   // '0'..'9' are 0x30..0x39, so the low nibble is already the digit value
   assign digit_val = rx_byte[3:0];

endmodule

// File: rtl/uart_num_tokenizer.sv
// UART number tokenizer: turns an ASCII byte stream such as "2 3 4 5 "
// into registered integer tokens with one-cycle valid pulses, flags
// malformed or out-of-range tokens, and counts emitted tokens.
// Optional feature macro: UART_NUM_TOKENIZER_NEG_EN enables a leading '-'.
// Ports:
//   clk          in  1      system clock
//   rst_n        in  1      synchronous active-low reset
//   i_enable     in  1      tokenizer active; low holds the block idle
//   i_rx_valid   in  1      strobe: i_rx_byte holds a received byte
//   i_rx_byte    in  8      received ASCII byte
//   o_num_valid  out 1      pulse: o_num_value holds a completed token
//   o_num_value  out VAL_W  token value (two's complement), held
//   o_err        out 1      pulse: current token rejected
//   o_err_code   out 2      rejection reason, held until next error
//   o_busy       out 1      a token is partially received
//   o_tok_cnt    out CNT_W  tokens emitted since i_enable rose, saturating
module uart_num_tokenizer
   import uart_num_tokenizer_pkg::*;
#(
   parameter int          VAL_W   = 32,
   parameter int unsigned MAX_VAL = 65535,
   parameter int          CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_enable,
   input  logic             i_rx_valid,
   input  logic [7:0]       i_rx_byte,
   output logic             o_num_valid,
   output logic [VAL_W-1:0] o_num_value,
   output logic             o_err,
   output logic [1:0]       o_err_code,
   output logic             o_busy,
   output logic [CNT_W-1:0] o_tok_cnt
);

   // Four spare bits so acc*10+9 can never wrap before the range check
   localparam int ACC_W = VAL_W + 4;

   logic [1:0]       state;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_next;
   logic             neg;
   logic             ovf;
   logic             enable_q;

   logic             is_digit;
   logic             is_delim;
   logic             is_minus;
   logic             is_bad;
   logic [3:0]       digit_val;

   ascii_char_classify u_classify (
      .rx_byte   (i_rx_byte),
      .is_digit  (is_digit),
      .is_delim  (is_delim),
      .is_minus  (is_minus),
      .digit_val (digit_val)
   );

   // '-' is never legal inside a digit run, even with signed tokens enabled
   assign is_bad   = is_minus || !(is_digit || is_delim);
   assign acc_next = acc * ACC_W'(10) + ACC_W'(digit_val);
   assign o_busy   = (state != ST_IDLE);

   // Main FSM, accumulator and token counter. Every return to IDLE clears
   // the accumulator and both flags so the next token starts clean.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         acc         <= '0;
         neg         <= 1'b0;
         ovf         <= 1'b0;
         enable_q    <= 1'b0;
         o_num_valid <= 1'b0;
         o_num_value <= '0;
         o_err       <= 1'b0;
         o_err_code  <= '0;
         o_tok_cnt   <= '0;
      end else begin
         enable_q    <= i_enable;
         o_num_valid <= 1'b0;
         o_err       <= 1'b0;
         if (!i_enable) begin
            state <= ST_IDLE;
            acc   <= '0;
            neg   <= 1'b0;
            ovf   <= 1'b0;
         end else begin
            if (!enable_q) begin
               o_tok_cnt <= '0;
            end
            if (i_rx_valid) begin
               case (state)
                  ST_IDLE: begin
                     if (is_delim) begin
                        state <= ST_IDLE;
                     end else if (is_digit) begin
                        acc   <= ACC_W'(digit_val);
                        state <= ST_DIGITS;
`ifdef UART_NUM_TOKENIZER_NEG_EN
                     end else if (is_minus) begin
                        neg   <= 1'b1;
                        state <= ST_NEG;
`endif
                     end else begin
                        o_err      <= 1'b1;
                        o_err_code <= ERR_BADCHAR;
                        state      <= ST_SKIP;
                     end
                  end
`ifdef UART_NUM_TOKENIZER_NEG_EN
                  ST_NEG: begin
                     if (is_digit) begin
                        acc   <= ACC_W'(digit_val);
                        state <= ST_DIGITS;
                     end else if (is_delim) begin
                        o_err      <= 1'b1;
                        o_err_code <= ERR_SIGN;
                        neg        <= 1'b0;
                        state      <= ST_IDLE;
                     end else begin
                        o_err      <= 1'b1;
                        o_err_code <= ERR_BADCHAR;
                        state      <= ST_SKIP;
                     end
                  end
`endif
                  ST_DIGITS: begin
                     if (is_digit) begin
                        // Once overflowed the accumulator stays frozen
                        if (!ovf) begin
                           if (acc_next > ACC_W'(MAX_VAL)) begin
                              ovf <= 1'b1;
                           end else begin
                              acc <= acc_next;
                           end
                        end
                     end else if (is_delim) begin
                        if (ovf) begin
                           o_err      <= 1'b1;
                           o_err_code <= ERR_OVF;
                        end else begin
                           o_num_valid <= 1'b1;
                           o_num_value <= neg ? (VAL_W'(0) - acc[VAL_W-1:0])
                                              : acc[VAL_W-1:0];
                           if (o_tok_cnt != {CNT_W{1'b1}}) begin
                              o_tok_cnt <= o_tok_cnt + 1'b1;
                           end
                        end
                        acc   <= '0;
                        neg   <= 1'b0;
                        ovf   <= 1'b0;
                        state <= ST_IDLE;
                     end else if (is_bad) begin
                        o_err      <= 1'b1;
                        o_err_code <= ERR_BADCHAR;
                        state      <= ST_SKIP;
                     end
                  end
                  ST_SKIP: begin
                     if (is_delim) begin
                        acc   <= '0;
                        neg   <= 1'b0;
                        ovf   <= 1'b0;
                        state <= ST_IDLE;
                     end
                  end
                  default: begin
                     state <= ST_IDLE;
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_num_tokenizer.sv
// Self-checking bench for uart_num_tokenizer: table of per-byte vectors
// with expected outputs, plus hand-written reset and saturation sequences.
module tb_uart_num_tokenizer;

   logic        clk;
   logic        rst_n;
   logic        i_enable;
   logic        i_rx_valid;
   logic [7:0]  i_rx_byte;
   logic        o_num_valid;
   logic [31:0] o_num_value;
   logic        o_err;
   logic [1:0]  o_err_code;
   logic        o_busy;
   logic [7:0]  o_tok_cnt;

   int compared;
   int mismatched;

   typedef struct {
      logic        en;
      logic        rv;
      logic [7:0]  b;
      logic        nv;
      logic [31:0] val;
      logic        er;
      logic [1:0]  code;
      logic        busy;
      logic [7:0]  cnt;
   } vec_t;

   vec_t vecs[$];

   uart_num_tokenizer #(.VAL_W(32), .MAX_VAL(65535), .CNT_W(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_enable    (i_enable),
      .i_rx_valid  (i_rx_valid),
      .i_rx_byte   (i_rx_byte),
      .o_num_valid (o_num_valid),
      .o_num_value (o_num_value),
      .o_err       (o_err),
      .o_err_code  (o_err_code),
      .o_busy      (o_busy),
      .o_tok_cnt   (o_tok_cnt)
   );

   // Free-running clock, 10 time-unit period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkValue(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic addVec(input logic en, input logic rv, input logic [7:0] b,
                         input logic nv, input logic [31:0] val, input logic er,
                         input logic [1:0] code, input logic busy,
                         input logic [7:0] cnt);
      vec_t v;
      v.en = en; v.rv = rv; v.b = b; v.nv = nv; v.val = val;
      v.er = er; v.code = code; v.busy = busy; v.cnt = cnt;
      vecs.push_back(v);
   endtask

   // Accepted byte with no pulse expected
   task automatic addByte(input logic [7:0] b, input logic busy, input logic [7:0] cnt);
      addVec(1'b1, 1'b1, b, 1'b0, 32'd0, 1'b0, 2'd0, busy, cnt);
   endtask

   // Accepted byte that completes a token
   task automatic addTok(input logic [7:0] b, input logic [31:0] val, input logic [7:0] cnt);
      addVec(1'b1, 1'b1, b, 1'b1, val, 1'b0, 2'd0, 1'b0, cnt);
   endtask

   // Accepted byte that raises an error
   task automatic addErr(input logic [7:0] b, input logic [1:0] code,
                         input logic busy, input logic [7:0] cnt);
      addVec(1'b1, 1'b1, b, 1'b0, 32'd0, 1'b1, code, busy, cnt);
   endtask

   // Drive one cycle of inputs, then land on the following negedge
   task automatic applyStimulus(input logic en, input logic rv, input logic [7:0] b);
      i_enable   = en;
      i_rx_valid = rv;
      i_rx_byte  = b;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic checkOutput(input int idx, input vec_t v);
      checkValue($sformatf("vec%0d.num_valid", idx), {31'd0, o_num_valid}, {31'd0, v.nv});
      checkValue($sformatf("vec%0d.err", idx), {31'd0, o_err}, {31'd0, v.er});
      checkValue($sformatf("vec%0d.busy", idx), {31'd0, o_busy}, {31'd0, v.busy});
      checkValue($sformatf("vec%0d.tok_cnt", idx), {24'd0, o_tok_cnt}, {24'd0, v.cnt});
      if (v.nv) checkValue($sformatf("vec%0d.num_value", idx), o_num_value, v.val);
      if (v.er) checkValue($sformatf("vec%0d.err_code", idx), {30'd0, o_err_code}, {30'd0, v.code});
   endtask

   task automatic checkAllZero(input string tag);
      checkValue({tag, ".num_valid"}, {31'd0, o_num_valid}, 32'd0);
      checkValue({tag, ".num_value"}, o_num_value, 32'd0);
      checkValue({tag, ".err"}, {31'd0, o_err}, 32'd0);
      checkValue({tag, ".err_code"}, {30'd0, o_err_code}, 32'd0);
      checkValue({tag, ".busy"}, {31'd0, o_busy}, 32'd0);
      checkValue({tag, ".tok_cnt"}, {24'd0, o_tok_cnt}, 32'd0);
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      rst_n      = 1'b0;
      i_enable   = 1'b0;
      i_rx_valid = 1'b0;
      i_rx_byte  = 8'h00;

      // "2 3 "
      addByte("2", 1, 0);
      addTok (" ", 32'd2, 1);
      addByte("3", 1, 1);
      addTok (" ", 32'd3, 2);
      // drop enable, then "  12\r\n 65535 65536 "
      addVec(0, 0, 8'h00, 0, 0, 0, 0, 0, 2);
      addByte(" ", 0, 0);
      addByte(" ", 0, 0);
      addByte("1", 1, 0);
      addByte("2", 1, 0);
      addTok (8'h0D, 32'd12, 1);
      addByte(8'h0A, 0, 1);
      addByte(" ", 0, 1);
      addByte("6", 1, 1);
      addByte("5", 1, 1);
      addByte("5", 1, 1);
      addByte("3", 1, 1);
      addByte("5", 1, 1);
      addTok (" ", 32'd65535, 2);
      addByte("6", 1, 2);
      addByte("5", 1, 2);
      addByte("5", 1, 2);
      addByte("3", 1, 2);
      addByte("6", 1, 2);
      addErr (" ", 2'd2, 0, 2);
      // byte offered while disabled is ignored; then "4a7 9 "
      addVec(0, 1, "7", 0, 0, 0, 0, 0, 2);
      addByte("4", 1, 0);
      addErr ("a", 2'd1, 1, 0);
      addByte("7", 1, 0);
      addByte(" ", 0, 0);
      addByte("9", 1, 0);
      addTok (" ", 32'd9, 1);
      // "12", enable drops (delimiter while disabled), re-enable, "5 "
      addByte("1", 1, 1);
      addByte("2", 1, 1);
      addVec(0, 1, " ", 0, 0, 0, 0, 0, 1);
      addVec(1, 0, 8'h00, 0, 0, 0, 0, 0, 0);
      addByte("5", 1, 0);
      addTok (" ", 32'd5, 1);
`ifdef UART_NUM_TOKENIZER_NEG_EN
      // "-7 - 3- "
      addByte("-", 1, 1);
      addByte("7", 1, 1);
      addTok (" ", 32'hFFFF_FFF9, 2);
      addByte("-", 1, 2);
      addErr (" ", 2'd3, 0, 2);
      addByte("3", 1, 2);
      addErr ("-", 2'd1, 1, 2);
      addByte(" ", 0, 2);
`else
      // "-7 " is rejected outright
      addErr ("-", 2'd1, 1, 1);
      addByte("7", 1, 1);
      addByte(" ", 0, 1);
`endif

      // Reset state
      repeat (2) @(negedge clk);
      checkAllZero("reset");
      rst_n = 1'b1;

      // Table-driven vectors
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].en, vecs[i].rv, vecs[i].b);
         checkOutput(i, vecs[i]);
      end

      // Reset in the middle of "123 "
      applyStimulus(1, 1, "1");
      checkValue("midrst.busy_before", {31'd0, o_busy}, 32'd1);
      applyStimulus(1, 1, "2");
      rst_n = 1'b0;
      applyStimulus(1, 0, 8'h00);
      checkAllZero("midrst");
      rst_n = 1'b1;
      applyStimulus(1, 1, "3");
      checkValue("midrst.busy_after", {31'd0, o_busy}, 32'd1);
      applyStimulus(1, 1, " ");
      checkValue("midrst.num_valid", {31'd0, o_num_valid}, 32'd1);
      checkValue("midrst.num_value", o_num_value, 32'd3);
      checkValue("midrst.tok_cnt", {24'd0, o_tok_cnt}, 32'd1);

      // Counter saturation: tokens 2..257, count pins at 255
      for (int k = 2; k <= 257; k++) begin
         applyStimulus(1, 1, "1");
         applyStimulus(1, 1, " ");
         if (k >= 254) begin
            checkValue($sformatf("sat%0d.num_valid", k), {31'd0, o_num_valid}, 32'd1);
            checkValue($sformatf("sat%0d.tok_cnt", k), {24'd0, o_tok_cnt},
                       (k > 255) ? 32'd255 : k);
         end
      end
      applyStimulus(1, 0, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
